amplitude_modulator_mc: RTL and testbench

Multi-channel, parametrised amplitude modulator. It scales NUM_CH voice samples by their per-channel ADSR envelope values and then by a shared master gain. One time-multiplexed WIDTH×WIDTH multiplier does all the scaling, and an optional slew limiter on master gain removes zipper noise when the I2C master amplitude register changes. It sits between the per-voice mixer/ADSR outputs and the output DAC/PWM stage. It replaces the single-channel, fixed-8-bit, two-multiplier modulator.

---
 rtl/amp_mod_pkg.sv | 35 +++
 rtl/amp_mul_trunc.sv | 22 ++
 rtl/amplitude_modulator_mc.sv | 176 +++++++++++++++++
 tb/tb_amplitude_modulator_mc.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/amp_mod_pkg.sv
`default_nettype none
// ============================================================================
// Module   : amp_mod_pkg
// Purpose  : Shared state encoding and counter-width helper for the
//            multi-channel amplitude modulator.
// Revision : 1.0  initial release
// ============================================================================
package amp_mod_pkg;

  // State encoding, shared with anything that decodes the modulator state.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MUL_ENV = 2'd1;
  localparam logic [1:0] ST_MUL_AMP = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_MUL_ENV = ST_MUL_ENV,
    S_MUL_AMP = ST_MUL_AMP,
    S_DONE    = ST_DONE
  } amp_state_t;

  // Width of a counter able to index n channels. Never returns less than 1 so
  // a single-channel build still has a legal (constant-zero) counter.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/amp_mul_trunc.sv
`default_nettype none
// ============================================================================
// Module   : amp_mul_trunc
// Purpose  : WIDTH x WIDTH unsigned multiplier returning only the upper half
//            of the product (truncating fixed-point scale by x/2^WIDTH).
// Revision : 1.0  initial release
// ============================================================================
module amp_mul_trunc #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi
);

  logic [2*WIDTH-1:0] w_prod;

  assign w_prod = i_a * i_b;
  assign o_hi   = w_prod[2*WIDTH-1:WIDTH];

endmodule
`default_nettype wire

// File: rtl/amplitude_modulator_mc.sv
`default_nettype none
// ============================================================================
// Module   : amplitude_modulator_mc
// Purpose  : Scales NUM_CH voice samples by their envelope and then by a
//            shared master gain using one time-multiplexed multiplier.
//            Results are double-buffered and published once per frame.
// Options  : AMP_MOD_RAMP_EN - when defined, master gain slews toward
//            master_amplitude by at most RAMP_STEP per frame; otherwise the
//            gain is loaded from master_amplitude when a frame is accepted.
// Revision : 1.0  initial release
// ============================================================================
module amplitude_modulator_mc
  import amp_mod_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_CH    = 4,
  parameter int RAMP_STEP = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH*WIDTH-1:0] waveform_in,
  input  logic [NUM_CH*WIDTH-1:0] envelope_value,
  input  logic [WIDTH-1:0]        master_amplitude,
  output logic [NUM_CH*WIDTH-1:0] amplitude_out,
  output logic                    out_valid,
  output logic                    overrun,
  output logic [WIDTH-1:0]        gain_now
);

  localparam int          CW      = clog2(NUM_CH);
  localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);

  amp_state_t              r_state;
  amp_state_t              w_state_next;
  logic                    w_accept;
  logic                    w_last_ch;

  logic [CW-1:0]           r_ch;
  logic [NUM_CH*WIDTH-1:0] r_wave;
  logic [NUM_CH*WIDTH-1:0] r_env;
  logic [WIDTH-1:0]        r_tmp;
  logic [NUM_CH*WIDTH-1:0] r_work;
  logic [NUM_CH*WIDTH-1:0] w_work_next;
  logic [NUM_CH*WIDTH-1:0] r_amp;
  logic [WIDTH-1:0]        r_gain;
  logic                    r_out_valid;

  logic [WIDTH-1:0]        w_wave_c;
  logic [WIDTH-1:0]        w_env_c;
  logic [WIDTH-1:0]        w_mul_a;
  logic [WIDTH-1:0]        w_mul_b;
  logic [WIDTH-1:0]        w_mul_p;

  assign in_ready      = (r_state == S_IDLE);
  assign overrun       = in_valid & ~in_ready;
  assign amplitude_out = r_amp;
  assign out_valid     = r_out_valid;
  assign gain_now      = r_gain;

  assign w_last_ch = (r_ch == LAST_CH);
  assign w_wave_c  = r_wave[r_ch*WIDTH +: WIDTH];
  assign w_env_c   = r_env[r_ch*WIDTH +: WIDTH];

  // Envelope stage multiplies sample by envelope; gain stage multiplies the
  // held intermediate by the frame gain.
  assign w_mul_a = (r_state == S_MUL_AMP) ? r_tmp  : w_wave_c;
  assign w_mul_b = (r_state == S_MUL_AMP) ? r_gain : w_env_c;

  amp_mul_trunc #(
    .WIDTH (WIDTH)
  ) u_mul (
    .i_a  (w_mul_a),
    .i_b  (w_mul_b),
    .o_hi (w_mul_p)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state decode: one envelope and one gain cycle per channel.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_next = S_MUL_ENV;
          w_accept     = 1'b1;
        end
      end
      S_MUL_ENV: w_state_next = S_MUL_AMP;
      S_MUL_AMP: w_state_next = w_last_ch ? S_DONE : S_MUL_ENV;
      S_DONE:    w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Work buffer with the current channel's gain-stage result merged in, so the
  // final channel lands in the published buffer on the same edge.
  always_comb begin
    w_work_next = r_work;
    w_work_next[r_ch*WIDTH +: WIDTH] = w_mul_p;
  end

`ifdef AMP_MOD_RAMP_EN
  localparam logic [WIDTH:0] STEP = (WIDTH+1)'(RAMP_STEP);
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_gain_ramp;

  // Slew gain toward the target; the step is clipped to the target so it can
  // neither overshoot nor wrap.
  always_comb begin
    w_diff      = '0;
    w_gain_ramp = r_gain;
    if (master_amplitude > r_gain) begin
      w_diff = {1'b0, master_amplitude} - {1'b0, r_gain};
      w_gain_ramp = (w_diff <= STEP) ? master_amplitude
                                     : r_gain + STEP[WIDTH-1:0];
    end else if (master_amplitude < r_gain) begin
      w_diff = {1'b0, r_gain} - {1'b0, master_amplitude};
      w_gain_ramp = (w_diff <= STEP) ? master_amplitude
                                     : r_gain - STEP[WIDTH-1:0];
    end
  end
`endif

  // Datapath: operand capture, per-channel arithmetic, publish and gain update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch        <= '0;
      r_wave      <= '0;
      r_env       <= '0;
      r_tmp       <= '0;
      r_work      <= '0;
      r_amp       <= '0;
      r_gain      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_accept) begin
        r_wave <= waveform_in;
        r_env  <= envelope_value;
        r_ch   <= '0;
`ifndef AMP_MOD_RAMP_EN
        r_gain <= master_amplitude;
`endif
      end
      case (r_state)
        S_MUL_ENV: r_tmp <= w_mul_p;
        S_MUL_AMP: begin
          r_work <= w_work_next;
          if (w_last_ch) begin
            r_ch        <= '0;
            r_amp       <= w_work_next;
            r_out_valid <= 1'b1;
          end else begin
            r_ch <= r_ch + 1'b1;
          end
        end
        S_DONE: begin
`ifdef AMP_MOD_RAMP_EN
          r_gain <= w_gain_ramp;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_amplitude_modulator_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_amplitude_modulator_mc
// Purpose  : Self-checking bench for amplitude_modulator_mc (W=8, N=4) with a
//            frame-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_amplitude_modulator_mc;

  localparam int STEP = 16;
`ifdef AMP_MOD_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] waveform_in;
  logic [31:0] envelope_value;
  logic [7:0]  master_amplitude;
  logic [31:0] amplitude_out;
  logic        out_valid;
  logic        overrun;
  logic [7:0]  gain_now;

  int n_pass = 0;
  int n_total = 0;

  int          m_gain;   // model gain register
  logic [31:0] m_last;   // model published outputs

  always #5 clk = ~clk;

  amplitude_modulator_mc #(
    .WIDTH     (8),
    .NUM_CH    (4),
    .RAMP_STEP (STEP)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .waveform_in      (waveform_in),
    .envelope_value   (envelope_value),
    .master_amplitude (master_amplitude),
    .amplitude_out    (amplitude_out),
    .out_valid        (out_valid),
    .overrun          (overrun),
    .gain_now         (gain_now)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // out[c] = floor(floor(w*e/256) * g / 256)
  function automatic logic [31:0] model_frame(input logic [31:0] w, input logic [31:0] e, input int g);
    logic [31:0] r;
    int wi, ei, t;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      wi = int'(w[c*8 +: 8]);
      ei = int'(e[c*8 +: 8]);
      t  = (wi * ei) / 256;
      r[c*8 +: 8] = 8'((t * g) / 256);
    end
    return r;
  endfunction

  function automatic int ramp_to(input int g, input int t);
    if (t > g) return (t - g <= STEP) ? t : g + STEP;
    if (t < g) return (g - t <= STEP) ? t : g - STEP;
    return g;
  endfunction

  // One frame starting in an IDLE cycle; ends in the next IDLE cycle.
  task automatic do_frame(input logic [31:0] w, input logic [31:0] e, input logic [7:0] m,
                          input bit mid, input logic [7:0] m2, input bit stress, output int fg);
    logic [31:0] exp_amp;
    check("idle_ready", {31'd0, in_ready}, 32'd1);
    waveform_in = w; envelope_value = e; master_amplitude = m; in_valid = 1'b1;
    if (!RAMP) m_gain = int'(m);
    fg = m_gain;
    exp_amp = model_frame(w, e, fg);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      waveform_in = $urandom; envelope_value = $urandom;
      if (mid && k == 3) master_amplitude = m2;
      in_valid = (stress && k <= 9) ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      check("overrun", {31'd0, overrun}, {31'd0, in_valid});
      check("out_valid", {31'd0, out_valid}, {31'd0, (k == 9)});
      check("in_ready", {31'd0, in_ready}, {31'd0, (k == 10)});
      if (k == 5) check("amp_hold", amplitude_out, m_last);
      if (k == 9) begin
        check("amp", amplitude_out, exp_amp);
        check("gain_frame", {24'd0, gain_now}, fg);
      end
      if (k == 10) begin
        if (RAMP) m_gain = ramp_to(fg, int'(master_amplitude));
        check("gain_next", {24'd0, gain_now}, m_gain);
        check("amp_after", amplitude_out, exp_amp);
        m_last = exp_amp;
      end
    end
  endtask

  task automatic back_to_back(input logic [31:0] w, input logic [31:0] e, input logic [7:0] m);
    logic [31:0] exp_amp;
    int phase;
    exp_amp = '0;
    waveform_in = w; envelope_value = e; master_amplitude = m; in_valid = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (cyc > 0) @(negedge clk);
      phase = cyc % 10;
      if (phase == 0) begin
        if (RAMP && cyc > 0) m_gain = ramp_to(m_gain, int'(m));
        if (!RAMP) m_gain = int'(m);
        exp_amp = model_frame(w, e, m_gain);
      end
      if (cyc == 29) in_valid = 1'b0;
      #1;
      check("b2b_ready", {31'd0, in_ready}, {31'd0, (phase == 0)});
      check("b2b_overrun", {31'd0, overrun}, {31'd0, (phase != 0 && in_valid)});
      check("b2b_out_valid", {31'd0, out_valid}, {31'd0, (phase == 9)});
      if (phase == 9) begin
        check("b2b_amp", amplitude_out, exp_amp);
        m_last = exp_amp;
      end
    end
    @(negedge clk);
    #1;
    if (RAMP) m_gain = ramp_to(m_gain, int'(m));
    check("b2b_idle", {31'd0, in_ready}, 32'd1);
    check("b2b_gain", {24'd0, gain_now}, m_gain);
  endtask

  task automatic reset_mid_frame();
    check("rmf_idle", {31'd0, in_ready}, 32'd1);
    waveform_in = $urandom; envelope_value = $urandom; master_amplitude = 8'hC0; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;   // cycle 1
    @(negedge clk);                    // cycle 2
    @(negedge clk); rst = 1'b1;        // cycle 3
    @(negedge clk); rst = 1'b0;
    #1;
    m_gain = 0; m_last = '0;
    check("rmf_out_valid", {31'd0, out_valid}, 32'd0);
    check("rmf_amp", amplitude_out, 32'd0);
    check("rmf_ready", {31'd0, in_ready}, 32'd1);
    check("rmf_gain", {24'd0, gain_now}, 32'd0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); #1;
      check("rmf_no_pulse", {31'd0, out_valid}, 32'd0);
    end
  endtask

  task automatic hard_reset();
    rst = 1'b1; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    m_gain = 0; m_last = '0;
  endtask

  int g;
  int up_tab[6]   = '{0, 16, 32, 48, 64, 64};
  int down_tab[5] = '{48, 32, 16, 5, 5};

  initial begin
    waveform_in = '0; envelope_value = '0; master_amplitude = '0;
    hard_reset();
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_amp", amplitude_out, 32'd0);
    check("rst_gain", {24'd0, gain_now}, 32'd0);

    // Directed channel vectors: (255,255), (128,128), (0,200), (200,0).
    do_frame({8'd200, 8'd0, 8'd128, 8'd255}, {8'd0, 8'd200, 8'd128, 8'd255},
             8'hFF, 1'b0, 8'h00, 1'b0, g);
`ifndef AMP_MOD_RAMP_EN
    check("spec_vector", amplitude_out, 32'h0000_3FFD);
`endif

    // Master 0xFF -> 0x00 mid-frame, then a frame at 0x00.
    do_frame($urandom, $urandom, 8'hFF, 1'b1, 8'h00, 1'b0, g);
`ifndef AMP_MOD_RAMP_EN
    check("mid_change_gain", g, 32'd255);
`endif
    do_frame($urandom, $urandom, 8'h00, 1'b0, 8'h00, 1'b0, g);
`ifndef AMP_MOD_RAMP_EN
    check("mid_change_zero", amplitude_out, 32'd0);
`endif

    // Random frames with overrun strobes during processing.
    for (int i = 0; i < 6; i++)
      do_frame($urandom, $urandom, 8'($urandom), 1'b0, 8'h00, 1'b1, g);

    back_to_back($urandom, $urandom, 8'($urandom_range(1, 255)));

    reset_mid_frame();
    do_frame($urandom, $urandom, 8'hA5, 1'b0, 8'h00, 1'b0, g);

    // Gain ramp up to 0x40 from reset, then down to 0x05.
    hard_reset();
    for (int i = 0; i < 6; i++) begin
      do_frame(32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h40, 1'b0, 8'h00, 1'b0, g);
`ifdef AMP_MOD_RAMP_EN
      check("ramp_up_gain", g, up_tab[i]);
      if (i == 0) check("ramp_frame1_zero", amplitude_out, 32'd0);
`endif
    end
    for (int i = 0; i < 5; i++) begin
      do_frame(32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h05, 1'b0, 8'h00, 1'b0, g);
`ifdef AMP_MOD_RAMP_EN
      check("ramp_down_gain", {24'd0, gain_now}, down_tab[i]);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
